// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole engine.
package mole_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PLAY,
      ST_DONE
   } state_t;

   localparam int unsigned ESC_W   = 16;
   localparam int unsigned ROUND_W = 8;

   // Number of set bits in a vector of up to 64 bits.
   function automatic int unsigned popcount(input logic [63:0] v);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < 64; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

endpackage

// File: rtl/mole_field_toggle_sync.sv
// Two-flop synchroniser for the raw slide switches plus a one-cycle buffer;
// toggle flags any edge (either direction) seen on the synchronised switch.
module toggle_sync #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] toggle
);

   logic [W-1:0] meta;
   logic [W-1:0] sync;
   logic [W-1:0] buffer;

   // Synchronise the asynchronous inputs and keep the previous synchronised value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta   <= '0;
         sync   <= '0;
         buffer <= '0;
      end else begin
         meta   <= din;
         sync   <= meta;
         buffer <= sync;
      end
   end

   assign toggle = sync ^ buffer;

endmodule

// File: rtl/mole_field.sv
// Whack-a-mole engine: timed spawn rounds, switch-toggle hits/misses,
// saturating weighted score and escaped-mole counter.
module mole_field
   import mole_pkg::*;
#(
   parameter int unsigned N_MOLES      = 10,
   parameter int unsigned SCORE_W      = 24,
   parameter int unsigned PERIOD_W     = 28,
   parameter int unsigned SPAWN_PERIOD = 200000000,
   parameter int unsigned ROUNDS       = 30,
   parameter int unsigned HIT_PTS      = 1,
   parameter int unsigned MISS_PTS     = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [N_MOLES-1:0] random,
   input  logic [N_MOLES-1:0] switch,
   output logic [N_MOLES-1:0] moles,
   output logic [SCORE_W-1:0] score,
   output logic [ESC_W-1:0]   escapes,
   output logic [ROUND_W-1:0] round,
   output logic               busy,
   output logic               done
);

   localparam int unsigned DELTA_W = SCORE_W + $clog2(N_MOLES) + 2;
   localparam logic [PERIOD_W-1:0] CNT_LAST = PERIOD_W'(SPAWN_PERIOD - 1);
   localparam logic signed [DELTA_W-1:0] SCORE_MAX = DELTA_W'({SCORE_W{1'b1}});

   state_t              state, state_next;
   logic [PERIOD_W-1:0] count, count_next;
   logic [N_MOLES-1:0]  moles_next;
   logic [SCORE_W-1:0]  score_next;
   logic [ESC_W-1:0]    escapes_next;
   logic [ROUND_W-1:0]  round_next;
   logic                done_next;

   logic [N_MOLES-1:0]  toggle;
   logic [N_MOLES-1:0]  hit_mask;
   logic [N_MOLES-1:0]  miss_mask;
   logic [N_MOLES-1:0]  kept;
   logic [N_MOLES-1:0]  onehot;
   logic [N_MOLES-1:0]  pattern;
   logic                play;
   logic                tick;
   logic                last;
   logic [DELTA_W-1:0]  hit_n;
   logic [DELTA_W-1:0]  miss_n;
   logic signed [DELTA_W-1:0] delta;
   logic signed [DELTA_W-1:0] sum;
   logic [SCORE_W-1:0]  score_sat;
   logic [ESC_W:0]      esc_sum;
   logic [ESC_W-1:0]    esc_sat;

   toggle_sync #(.W(N_MOLES)) u_sync (
      .clk    (clk),
      .rst    (rst),
      .din    (switch),
      .toggle (toggle)
   );

   assign busy = (state == ST_PLAY);

   // Hit/miss judgement, saturated score, spawn pattern and escape accumulation.
   always_comb begin
      play      = (state == ST_PLAY);
      tick      = play && (count == '0);
      last      = tick && (round == ROUND_W'(ROUNDS));
      hit_mask  = play ? (toggle & moles)  : '0;
      miss_mask = play ? (toggle & ~moles) : '0;
      kept      = moles & ~hit_mask;

      hit_n  = DELTA_W'(popcount(64'(hit_mask)));
      miss_n = DELTA_W'(popcount(64'(miss_mask)));
      delta  = hit_n * DELTA_W'(HIT_PTS) - miss_n * DELTA_W'(MISS_PTS);
      sum    = DELTA_W'(score) + delta;
      if (sum[DELTA_W-1])       score_sat = '0;
      else if (sum > SCORE_MAX) score_sat = '1;
      else                      score_sat = sum[SCORE_W-1:0];

      for (int unsigned i = 0; i < N_MOLES; i++) begin
         onehot[i] = (i == (32'(round) % N_MOLES));
      end
      pattern = (random == '0) ? onehot : random;

      // Hit lamps are removed before counting, so a same-cycle hit is never an escape.
      esc_sum = {1'b0, escapes} + (ESC_W + 1)'(popcount(64'(kept)));
      esc_sat = esc_sum[ESC_W] ? '1 : esc_sum[ESC_W-1:0];
   end

   // Game FSM next state and next datapath values.
   always_comb begin
      state_next   = state;
      count_next   = count;
      moles_next   = kept;
      score_next   = score_sat;
      escapes_next = escapes;
      round_next   = round;
      done_next    = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_next   = ST_PLAY;
               count_next   = '0;
               moles_next   = '0;
               score_next   = '0;
               escapes_next = '0;
               round_next   = '0;
            end
         end
         ST_PLAY: begin
            count_next = (count == CNT_LAST) ? '0 : count + 1'b1;
            if (tick) begin
               escapes_next = esc_sat;
               if (last) begin
                  state_next = ST_DONE;
                  moles_next = '0;
                  done_next  = 1'b1;
               end else begin
                  moles_next = pattern;
                  round_next = round + 1'b1;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         count   <= '0;
         moles   <= '0;
         score   <= '0;
         escapes <= '0;
         round   <= '0;
         done    <= 1'b0;
      end else begin
         state   <= state_next;
         count   <= count_next;
         moles   <= moles_next;
         score   <= score_next;
         escapes <= escapes_next;
         round   <= round_next;
         done    <= done_next;
      end
   end

endmodule

// File: tb/tb_mole_field.sv
// Bench for mole_field: behavioural game model compared every cycle,
// plus directed literal checks of the key scenarios.
module tb_mole_field;

   localparam int N      = 10;
   localparam int PERIOD = 8;
   localparam int RNDS   = 3;
   localparam int HIT    = 2;
   localparam int MISS   = 1;
   localparam int SMAX   = (1 << 24) - 1;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [9:0]  random;
   logic [9:0]  switch;
   logic [9:0]  moles;
   logic [23:0] score;
   logic [15:0] escapes;
   logic [7:0]  round;
   logic        busy;
   logic        done;

   int checks;
   int fails;

   mole_field #(
      .N_MOLES      (10),
      .SCORE_W      (24),
      .PERIOD_W     (28),
      .SPAWN_PERIOD (PERIOD),
      .ROUNDS       (RNDS),
      .HIT_PTS      (HIT),
      .MISS_PTS     (MISS)
   ) dut (
      .clk     (clk),
      .rst     (rst_n),
      .start   (start),
      .random  (random),
      .switch  (switch),
      .moles   (moles),
      .score   (score),
      .escapes (escapes),
      .round   (round),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int cnt(input logic [9:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 10; i++) if (v[i]) n++;
      return n;
   endfunction

   // Behavioural model: a game is a run of PLAY cycles numbered from 0; every
   // PERIOD-th cycle spawns, and the spawn slot after RNDS spawns ends the game.
   logic [9:0] hist [4];
   bit         m_play;
   int         m_phase;
   logic [9:0] m_moles;
   int         m_score;
   int         m_esc;
   int         m_round;
   bit         m_done;

   always @(posedge clk or negedge rst_n) begin
      logic [9:0] tg;
      int         s;
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) hist[i] = '0;
         m_play = 0; m_phase = 0; m_moles = '0; m_score = 0;
         m_esc = 0; m_round = 0; m_done = 0;
      end else begin
         // switch sampled now is hist[0]; a change is scored once it is 2 edges old
         for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = switch;
         tg = hist[2] ^ hist[3];
         m_done = 0;
         if (!m_play) begin
            if (start) begin
               m_play = 1; m_phase = 0; m_moles = '0;
               m_score = 0; m_esc = 0; m_round = 0;
            end
         end else begin
            s = m_score + HIT * cnt(tg & m_moles) - MISS * cnt(tg & ~m_moles);
            m_score = (s < 0) ? 0 : ((s > SMAX) ? SMAX : s);
            m_moles = m_moles & ~tg;
            if (m_phase % PERIOD == 0) begin
               m_esc = m_esc + cnt(m_moles);
               if (m_esc > 65535) m_esc = 65535;
               if (m_round == RNDS) begin
                  m_play = 0;
                  m_moles = '0;
                  m_done = 1;
               end else begin
                  m_moles = (random != 0) ? random : 10'(1 << (m_round % N));
                  m_round++;
               end
            end
            m_phase++;
         end
      end
   end

   // Compare every cycle, just after the active edge, while out of reset.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst_n) begin
            check("model_moles",   32'(moles),   32'(m_moles));
            check("model_score",   32'(score),   32'(m_score));
            check("model_escapes", 32'(escapes), 32'(m_esc));
            check("model_round",   32'(round),   32'(m_round));
            check("model_busy",    32'(busy),    32'(m_play));
            check("model_done",    32'(done),    32'(m_done));
         end
      end
   end

   task automatic negs(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Directed scenario; comments give the negedge index relative to start.
   initial begin
      checks = 0;
      fails  = 0;
      rst_n = 1'b0; start = 1'b0; random = '0; switch = '0;
      negs(3);
      rst_n = 1'b1;
      negs(1);
      check("reset_moles",   32'(moles),   32'h0);
      check("reset_score",   32'(score),   32'h0);
      check("reset_escapes", 32'(escapes), 32'h0);
      check("reset_round",   32'(round),   32'h0);
      check("reset_busy",    32'(busy),    32'h0);
      check("reset_done",    32'(done),    32'h0);

      // N0
      start = 1'b1; random = 10'h005;
      negs(1); // N1
      start = 1'b0;
      negs(1); // N2
      check("first_spawn_moles", 32'(moles), 32'h005);
      check("first_spawn_round", 32'(round), 32'h1);
      check("first_spawn_busy",  32'(busy),  32'h1);
      switch = 10'h001;
      negs(3); // N5
      check("hit_moles", 32'(moles), 32'h004);
      check("hit_score", 32'(score), 32'h2);
      switch = 10'h003;
      negs(3); // N8
      check("miss_score_2to1", 32'(score), 32'h1);
      switch = 10'h001;
      negs(3); // N11
      check("miss_score_1to0", 32'(score), 32'h0);
      switch = 10'h003;
      negs(3); // N14
      check("miss_floor", 32'(score), 32'h0);
      check("escape_after_spawn2", 32'(escapes), 32'h1);
      switch = 10'h006; random = 10'h300;
      negs(1); // N15
      negs(3); // N18
      check("spawn_hit_score",   32'(score),   32'h4);
      check("spawn_hit_escapes", 32'(escapes), 32'h1);
      check("spawn_hit_moles",   32'(moles),   32'h300);
      check("spawn_hit_round",   32'(round),   32'h3);
      negs(8); // N26
      check("end_done",    32'(done),    32'h1);
      check("end_moles",   32'(moles),   32'h0);
      check("end_escapes", 32'(escapes), 32'h3);
      check("end_busy",    32'(busy),    32'h0);
      negs(1); // N27
      check("done_pulse_width", 32'(done), 32'h0);
      start = 1'b1; // ignored while idle for a cycle? no: state is DONE, so this starts
      random = 10'h0F0;
      negs(1); // N28 equivalent (start sampled at following edge)
      start = 1'b0;
      negs(1);
      check("restart_score",   32'(score),   32'h0);
      check("restart_escapes", 32'(escapes), 32'h0);
      check("restart_busy",    32'(busy),    32'h1);
      check("restart_moles",   32'(moles),   32'h0F0);
      random = 10'h00F;
      negs(10);
      random = 10'h000;
      negs(6);
      check("zero_random_onehot", 32'(moles),   32'h004);
      check("zero_random_round",  32'(round),   32'h3);
      check("game2_escapes",      32'(escapes), 32'h8);
      start = 1'b1; // start during PLAY has no effect
      negs(1);
      start = 1'b0;
      check("start_in_play_round", 32'(round), 32'h3);
      negs(1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_moles",   32'(moles),   32'h0);
      check("async_rst_score",   32'(score),   32'h0);
      check("async_rst_escapes", 32'(escapes), 32'h0);
      check("async_rst_round",   32'(round),   32'h0);
      check("async_rst_busy",    32'(busy),    32'h0);
      check("async_rst_done",    32'(done),    32'h0);
      negs(2);
      rst_n = 1'b1;
      negs(4);
      check("idle_after_rst_busy", 32'(busy), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
